// File: rtl/vpifo_pkg.sv
// Shared definitions for the vPIFO port controller: capacity helper, stall
// counter width and the registered core command encoding.
package vpifo_pkg;

  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP
  } op_e;

  // A BMW tree of depth LEVEL holds 2 + 4 + ... + 2**LEVEL entries.
  function automatic int vpifo_cap(input int level);
    return (1 << (level + 1)) - 2;
  endfunction

endpackage

// File: rtl/vpifo_port_arbiter_if.sv
// Push/pop request, pop-result and core-command signals of the port controller.
// slave = controller side, master = sources/core side.
interface vpifo_port_arbiter_if #(
  parameter int PTW = 16,
  parameter int TNB = 2
);
  logic           i_push_valid;
  logic           o_push_ready;
  logic [TNB-1:0] i_push_tree_id;
  logic [PTW-1:0] i_push_data;
  logic           i_pop_valid;
  logic           o_pop_ready;
  logic [TNB-1:0] i_pop_tree_id;
  logic           o_pop_data_valid;
  logic [PTW-1:0] o_pop_data;
  logic [TNB-1:0] o_pop_tree_id;
  logic           o_core_push;
  logic           o_core_pop;
  logic [TNB-1:0] o_core_tree_id;
  logic [PTW-1:0] o_core_push_data;
  logic [PTW-1:0] i_core_pop_data;

  modport slave (
    input  i_push_valid, i_push_tree_id, i_push_data,
    input  i_pop_valid, i_pop_tree_id, i_core_pop_data,
    output o_push_ready, o_pop_ready,
    output o_pop_data_valid, o_pop_data, o_pop_tree_id,
    output o_core_push, o_core_pop, o_core_tree_id, o_core_push_data
  );

  modport master (
    output i_push_valid, i_push_tree_id, i_push_data,
    output i_pop_valid, i_pop_tree_id, i_core_pop_data,
    input  o_push_ready, o_pop_ready,
    input  o_pop_data_valid, o_pop_data, o_pop_tree_id,
    input  o_core_push, o_core_pop, o_core_tree_id, o_core_push_data
  );
endinterface

// File: rtl/vpifo_pop_tag_pipe.sv
// Shift register carrying (valid, tree id) of issued pops until the core
// returns their data; synchronous clear discards everything in flight.
module vpifo_pop_tag_pipe #(
  parameter int TNB   = 2,
  parameter int DEPTH = 3
) (
  input  logic           clk_i,
  input  logic           clr_i,
  input  logic           vld_i,
  input  logic [TNB-1:0] tid_i,
  output logic           vld_o,
  output logic [TNB-1:0] tid_o
);
  logic           vld_q [DEPTH];
  logic [TNB-1:0] tid_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        tid_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i;
      tid_q[0] <= tid_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign tid_o = tid_q[DEPTH-1];
endmodule

// File: rtl/vpifo_port_arbiter.sv
// Flow-controlled push/pop port in front of the multi-tree vPIFO core.
// Define VPIFO_PORT_STATS_EN to build the per-tree full/empty stall counters.
module vpifo_port_arbiter
  import vpifo_pkg::*;
#(
  parameter int PTW      = 16,
  parameter int TREE_NUM = 4,
  parameter int LEVEL    = 4,
  parameter int POP_LAT  = 2,
  parameter int TNB      = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  vpifo_port_arbiter_if.slave             bus,
  output logic [TREE_NUM-1:0]             o_full,
  output logic [TREE_NUM-1:0]             o_empty,
  output logic [TREE_NUM*STALL_CNT_W-1:0] o_stall_cnt
);
  localparam int CAP = vpifo_cap(LEVEL);
  localparam int OCW = $clog2(CAP + 1);
  localparam int NID = 1 << TNB;
  localparam logic [OCW-1:0] CAP_V = OCW'(CAP);
  // One bit per encodable id, set only for ids that name an existing tree.
  localparam logic [NID-1:0] ID_OK = {NID{1'b1}} >> (NID - TREE_NUM);

  logic [OCW-1:0] occ_q [TREE_NUM];
  logic [OCW-1:0] occ_d [TREE_NUM];
  logic           pri_pop_q, pri_pop_d;
  op_e            op_q, op_d;
  logic [TNB-1:0] core_tid_q, core_tid_d;
  logic [PTW-1:0] core_data_q, core_data_d;
  logic           pop_vld_q;
  logic [PTW-1:0] pop_data_q;
  logic [TNB-1:0] pop_tid_q;
  logic           tag_vld;
  logic [TNB-1:0] tag_tid;

  logic           push_in_rng, pop_in_rng;
  logic [OCW-1:0] push_occ, pop_occ;
  logic           push_ok, pop_ok, push_fire, pop_fire;

  assign push_in_rng = bus.i_push_valid && ID_OK[bus.i_push_tree_id];
  assign pop_in_rng  = bus.i_pop_valid && ID_OK[bus.i_pop_tree_id];
  assign push_occ    = push_in_rng ? occ_q[bus.i_push_tree_id] : '0;
  assign pop_occ     = pop_in_rng ? occ_q[bus.i_pop_tree_id] : '0;
  assign push_ok     = push_in_rng && (push_occ != CAP_V);
  assign pop_ok      = pop_in_rng && (pop_occ != '0);
  assign push_fire   = push_ok && (!pop_ok || !pri_pop_q) && !i_rst;
  assign pop_fire    = pop_ok && (!push_ok || pri_pop_q) && !i_rst;

  assign bus.o_push_ready = push_fire;
  assign bus.o_pop_ready  = pop_fire;

  always_comb begin
    for (int t = 0; t < TREE_NUM; t++) begin
      occ_d[t] = occ_q[t];
      if (push_fire && (bus.i_push_tree_id == TNB'(t))) occ_d[t] = occ_q[t] + OCW'(1);
      if (pop_fire && (bus.i_pop_tree_id == TNB'(t)))   occ_d[t] = occ_q[t] - OCW'(1);
    end
    // The priority bit only moves when both sides were eligible.
    pri_pop_d   = (push_ok && pop_ok) ? !pri_pop_q : pri_pop_q;
    op_d        = OP_IDLE;
    core_tid_d  = '0;
    core_data_d = '0;
    if (push_fire) begin
      op_d        = OP_PUSH;
      core_tid_d  = bus.i_push_tree_id;
      core_data_d = bus.i_push_data;
    end else if (pop_fire) begin
      op_d        = OP_POP;
      core_tid_d  = bus.i_pop_tree_id;
    end
  end

  // Stage boundary: handshake -> registered core command, tag enters the pipe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int t = 0; t < TREE_NUM; t++) occ_q[t] <= '0;
      pri_pop_q   <= 1'b1;
      op_q        <= OP_IDLE;
      core_tid_q  <= '0;
      core_data_q <= '0;
      pop_vld_q   <= 1'b0;
      pop_data_q  <= '0;
      pop_tid_q   <= '0;
    end else begin
      occ_q       <= occ_d;
      pri_pop_q   <= pri_pop_d;
      op_q        <= op_d;
      core_tid_q  <= core_tid_d;
      core_data_q <= core_data_d;
      pop_vld_q   <= tag_vld;
      if (tag_vld) begin
        pop_data_q <= bus.i_core_pop_data;
        pop_tid_q  <= tag_tid;
      end
    end
  end

  vpifo_pop_tag_pipe #(
    .TNB   (TNB),
    .DEPTH (POP_LAT + 1)
  ) u_tag_pipe (
    .clk_i (i_clk),
    .clr_i (i_rst),
    .vld_i (pop_fire),
    .tid_i (bus.i_pop_tree_id),
    .vld_o (tag_vld),
    .tid_o (tag_tid)
  );

  assign bus.o_core_push      = (op_q == OP_PUSH);
  assign bus.o_core_pop       = (op_q == OP_POP);
  assign bus.o_core_tree_id   = core_tid_q;
  assign bus.o_core_push_data = core_data_q;
  assign bus.o_pop_data_valid = pop_vld_q;
  assign bus.o_pop_data       = pop_data_q;
  assign bus.o_pop_tree_id    = pop_tid_q;

  for (genvar g = 0; g < TREE_NUM; g++) begin : g_status
    assign o_full[g]  = (occ_q[g] == CAP_V);
    assign o_empty[g] = (occ_q[g] == '0);
  end

`ifdef VPIFO_PORT_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q [TREE_NUM];
  logic [STALL_CNT_W-1:0] stall_d [TREE_NUM];
  logic                   push_stall, pop_stall;

  function automatic logic [STALL_CNT_W-1:0] sat_add(input logic [STALL_CNT_W-1:0] a,
                                                     input logic [1:0] inc);
    logic [STALL_CNT_W:0] s;
    s = {1'b0, a} + {{(STALL_CNT_W-1){1'b0}}, inc};
    return s[STALL_CNT_W] ? '1 : s[STALL_CNT_W-1:0];
  endfunction

  // Arbitration losses are deliberately not stalls: only full/empty blocks count.
  assign push_stall = push_in_rng && (push_occ == CAP_V);
  assign pop_stall  = pop_in_rng && (pop_occ == '0);

  always_comb begin
    for (int t = 0; t < TREE_NUM; t++) begin
      stall_d[t] = sat_add(stall_q[t],
                           {1'b0, push_stall && (bus.i_push_tree_id == TNB'(t))} +
                           {1'b0, pop_stall && (bus.i_pop_tree_id == TNB'(t))});
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int t = 0; t < TREE_NUM; t++) stall_q[t] <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  for (genvar g = 0; g < TREE_NUM; g++) begin : g_stall
    assign o_stall_cnt[g*STALL_CNT_W +: STALL_CNT_W] = stall_q[g];
  end
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vpifo_port_arbiter.sv
// Self-checking bench for vpifo_port_arbiter: behavioural PIFO core plus a
// transaction-level reference of occupancy, arbitration and result timing.
module tb_vpifo_port_arbiter;
  localparam int PTW      = 16;
  localparam int TREE_NUM = 4;
  localparam int LEVEL    = 4;
  localparam int POP_LAT  = 2;
  localparam int TNB      = 2;
  localparam int CAP      = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vpifo_port_arbiter_if #(.PTW(PTW), .TNB(TNB)) bus();
  logic [TREE_NUM-1:0]    full, empty;
  logic [TREE_NUM*16-1:0] stall;

  vpifo_port_arbiter #(
    .PTW(PTW), .TREE_NUM(TREE_NUM), .LEVEL(LEVEL), .POP_LAT(POP_LAT), .TNB(TNB)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .o_full(full), .o_empty(empty), .o_stall_cnt(stall)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: PIFO per tree, pop returns the smallest value POP_LAT later.
  logic [PTW-1:0] cq [TREE_NUM][$];
  logic [PTW-1:0] core_c1 = '0, core_c2 = '0;
  assign bus.i_core_pop_data = core_c2;

  always @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < TREE_NUM; t++) cq[t].delete();
      core_c1 <= '0;
      core_c2 <= '0;
    end else begin
      core_c2 <= core_c1;
      core_c1 <= '0;
      if (bus.o_core_push) cq[bus.o_core_tree_id].push_back(bus.o_core_push_data);
      if (bus.o_core_pop && cq[bus.o_core_tree_id].size() > 0) begin
        int mi;
        mi = 0;
        for (int i = 1; i < cq[bus.o_core_tree_id].size(); i++)
          if (cq[bus.o_core_tree_id][i] < cq[bus.o_core_tree_id][mi]) mi = i;
        core_c1 <= cq[bus.o_core_tree_id][mi];
        cq[bus.o_core_tree_id].delete(mi);
      end
    end
  end

  // Reference model: contents per tree, priority flag, expected outputs.
  int             m_occ [TREE_NUM];
  logic [PTW-1:0] m_vals [TREE_NUM][$];
  bit             m_pri_pop = 1'b1;
  int             m_stall [TREE_NUM];
  bit             r_v [5];
  logic [PTW-1:0] r_d [5];
  int             r_t [5];
  bit             e_push = 0, e_pop = 0;
  int             e_tid = 0;
  logic [PTW-1:0] e_data = '0, e_pd = '0;
  int             e_ptid = 0;

  function automatic bit m_push_legal();
    return bus.i_push_valid && (int'(bus.i_push_tree_id) < TREE_NUM) &&
           (m_occ[bus.i_push_tree_id] < CAP);
  endfunction
  function automatic bit m_pop_legal();
    return bus.i_pop_valid && (int'(bus.i_pop_tree_id) < TREE_NUM) &&
           (m_occ[bus.i_pop_tree_id] > 0);
  endfunction
  function automatic bit m_push_rdy();
    return !rst && m_push_legal() && (!m_pop_legal() || !m_pri_pop);
  endfunction
  function automatic bit m_pop_rdy();
    return !rst && m_pop_legal() && (!m_push_legal() || m_pri_pop);
  endfunction

  always @(posedge clk) begin
    bit pl, ql, pr, qr;
    int pt, qt, mi;
    pl = m_push_legal(); ql = m_pop_legal();
    pr = m_push_rdy();   qr = m_pop_rdy();
    pt = int'(bus.i_push_tree_id);
    qt = int'(bus.i_pop_tree_id);
    if (rst) begin
      for (int t = 0; t < TREE_NUM; t++) begin
        m_occ[t] = 0; m_vals[t].delete(); m_stall[t] = 0;
      end
      for (int s = 0; s < 5; s++) begin r_v[s] = 0; r_d[s] = '0; r_t[s] = 0; end
      m_pri_pop = 1; e_push = 0; e_pop = 0; e_tid = 0; e_data = '0; e_pd = '0; e_ptid = 0;
    end else begin
      if (bus.i_push_valid && pt < TREE_NUM && m_occ[pt] == CAP && m_stall[pt] < 65535)
        m_stall[pt]++;
      if (bus.i_pop_valid && qt < TREE_NUM && m_occ[qt] == 0 && m_stall[qt] < 65535)
        m_stall[qt]++;
      for (int s = 4; s > 1; s--) begin r_v[s] = r_v[s-1]; r_d[s] = r_d[s-1]; r_t[s] = r_t[s-1]; end
      r_v[1] = 0;
      e_push = 0; e_pop = 0; e_tid = 0; e_data = '0;
      if (pr) begin
        m_vals[pt].push_back(bus.i_push_data);
        m_occ[pt]++;
        e_push = 1; e_tid = pt; e_data = bus.i_push_data;
      end
      if (qr) begin
        mi = 0;
        for (int i = 1; i < m_vals[qt].size(); i++) if (m_vals[qt][i] < m_vals[qt][mi]) mi = i;
        r_v[1] = 1; r_d[1] = m_vals[qt][mi]; r_t[1] = qt;
        m_vals[qt].delete(mi);
        m_occ[qt]--;
        e_pop = 1; e_tid = qt;
      end
      if (pl && ql) m_pri_pop = !m_pri_pop;
      if (r_v[4]) begin e_pd = r_d[4]; e_ptid = r_t[4]; end
    end
  end

  int             obs_cyc [$];
  logic [PTW-1:0] obs_d [$];
  int             obs_t [$];

  // Continuous per-cycle comparison of every output against the reference.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [TREE_NUM-1:0]    xf, xe;
      logic [TREE_NUM*16-1:0] xs;
      for (int t = 0; t < TREE_NUM; t++) begin
        xf[t] = (m_occ[t] == CAP);
        xe[t] = (m_occ[t] == 0);
      end
      xs = '0;
`ifdef VPIFO_PORT_STATS_EN
      for (int t = 0; t < TREE_NUM; t++) xs[t*16 +: 16] = 16'(m_stall[t]);
`endif
      n_checks++;
      if (bus.o_push_ready !== m_push_rdy()) begin
        n_fail++; $display("FAIL mon_push_ready t=%0t got=%b exp=%b", $time, bus.o_push_ready, m_push_rdy());
      end
      n_checks++;
      if (bus.o_pop_ready !== m_pop_rdy()) begin
        n_fail++; $display("FAIL mon_pop_ready t=%0t got=%b exp=%b", $time, bus.o_pop_ready, m_pop_rdy());
      end
      n_checks++;
      if (bus.o_core_push !== e_push || bus.o_core_pop !== e_pop ||
          bus.o_core_tree_id !== TNB'(e_tid) || bus.o_core_push_data !== e_data) begin
        n_fail++;
        $display("FAIL mon_core_cmd t=%0t got=%b/%b/%0d/%h exp=%b/%b/%0d/%h", $time,
                 bus.o_core_push, bus.o_core_pop, bus.o_core_tree_id, bus.o_core_push_data,
                 e_push, e_pop, e_tid, e_data);
      end
      n_checks++;
      if (bus.o_pop_data_valid !== r_v[4]) begin
        n_fail++; $display("FAIL mon_pop_valid t=%0t got=%b exp=%b", $time, bus.o_pop_data_valid, r_v[4]);
      end
      n_checks++;
      if (bus.o_pop_data !== e_pd || bus.o_pop_tree_id !== TNB'(e_ptid)) begin
        n_fail++;
        $display("FAIL mon_pop_result t=%0t got=%h/%0d exp=%h/%0d", $time,
                 bus.o_pop_data, bus.o_pop_tree_id, e_pd, e_ptid);
      end
      n_checks++;
      if (full !== xf || empty !== xe) begin
        n_fail++; $display("FAIL mon_status t=%0t full=%b/%b empty=%b/%b", $time, full, xf, empty, xe);
      end
      n_checks++;
      if (stall !== xs) begin
        n_fail++; $display("FAIL mon_stall t=%0t got=%h exp=%h", $time, stall, xs);
      end
      if (bus.o_pop_data_valid === 1'b1) begin
        obs_cyc.push_back(cyc); obs_d.push_back(bus.o_pop_data); obs_t.push_back(int'(bus.o_pop_tree_id));
      end
    end
  end

  task automatic drive(input bit pv, input int pid, input logic [PTW-1:0] pd,
                       input bit qv, input int qid);
    bus.i_push_valid   = pv;
    bus.i_push_tree_id = TNB'(pid);
    bus.i_push_data    = pd;
    bus.i_pop_valid    = qv;
    bus.i_pop_tree_id  = TNB'(qid);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive(0, 0, '0, 0, 0);
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 0, 16'h1234, 1, 0);
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_push_ready !== 1'b0 || bus.o_pop_ready !== 1'b0) begin
        n_fail++; $display("FAIL reset_ready push=%b pop=%b exp 0 0", bus.o_push_ready, bus.o_pop_ready);
      end
      n_checks++;
      if (empty !== 4'hF || full !== 4'h0) begin
        n_fail++; $display("FAIL reset_status empty=%h full=%h exp F 0", empty, full);
      end
      n_checks++;
      if (bus.o_pop_data_valid !== 1'b0 || bus.o_core_push !== 1'b0 || bus.o_core_pop !== 1'b0) begin
        n_fail++; $display("FAIL reset_outputs pv=%b cpush=%b cpop=%b exp 0", bus.o_pop_data_valid,
                           bus.o_core_push, bus.o_core_pop);
      end
      step();
    end
    drive(0, 0, '0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    int hs [$];
    for (int i = 0; i < CAP; i++) begin
      drive(1, 0, 16'(4096 + i), 0, 0);
      @(negedge clk);
      n_checks++;
      if (bus.o_push_ready !== 1'b1) begin
        n_fail++; $display("FAIL fill_ready i=%0d got=%b exp 1", i, bus.o_push_ready);
      end
      step();
    end
    drive(1, 0, 16'(4096 + CAP), 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_push_ready !== 1'b0 || full[0] !== 1'b1) begin
        n_fail++; $display("FAIL overfill k=%0d ready=%b full0=%b exp 0 1", k, bus.o_push_ready, full[0]);
      end
      step();
    end
    drive(0, 0, '0, 0, 0);
    @(negedge clk);
    n_checks++;
`ifdef VPIFO_PORT_STATS_EN
    if (stall[15:0] !== 16'd5) begin
      n_fail++; $display("FAIL stall_tree0 got=%0d exp=5", stall[15:0]);
    end
`else
    if (stall !== '0) begin
      n_fail++; $display("FAIL stall_off got=%h exp=0", stall);
    end
`endif
    step();
    obs_cyc.delete(); obs_d.delete(); obs_t.delete();
    for (int i = 0; i < CAP; i++) begin
      drive(0, 0, '0, 1, 0);
      @(negedge clk);
      n_checks++;
      if (bus.o_pop_ready !== 1'b1) begin
        n_fail++; $display("FAIL drain_ready i=%0d got=%b exp 1", i, bus.o_pop_ready);
      end
      hs.push_back(cyc);
      step();
    end
    drive(0, 0, '0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_pop_ready !== 1'b0) begin
        n_fail++; $display("FAIL underflow k=%0d ready=%b exp 0", k, bus.o_pop_ready);
      end
      step();
    end
    drive(0, 0, '0, 0, 0);
    n_checks++;
    if (empty[0] !== 1'b1) begin
      n_fail++; $display("FAIL drain_empty got=%b exp 1", empty[0]);
    end
    n_checks++;
    if (obs_d.size() != CAP) begin
      n_fail++; $display("FAIL drain_count got=%0d exp=%0d", obs_d.size(), CAP);
    end else begin
      for (int i = 0; i < CAP; i++) begin
        n_checks++;
        if (obs_d[i] !== 16'(4096 + i) || obs_t[i] != 0 || obs_cyc[i] - hs[i] != 4) begin
          n_fail++;
          $display("FAIL drain_item i=%0d data=%h tree=%0d lat=%0d exp %h 0 4", i, obs_d[i], obs_t[i],
                   obs_cyc[i] - hs[i], 16'(4096 + i));
        end
      end
    end
  endtask

  task automatic test_contested();
    bit xp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 16'($urandom), 0, 0);
      @(negedge clk);
      n_checks++;
      if (bus.o_push_ready !== 1'b1) begin
        n_fail++; $display("FAIL contest_setup i=%0d got=%b exp 1", i, bus.o_push_ready);
      end
      step();
    end
    for (int k = 0; k < 14; k++) begin
      drive(1, 1, 16'($urandom), 1, 0);
      xp = (k < 10) && (k % 2 == 0);
      @(negedge clk);
      n_checks++;
      if (bus.o_pop_ready !== xp || bus.o_push_ready !== !xp) begin
        n_fail++; $display("FAIL contest_grant k=%0d pop=%b push=%b exp %b %b", k,
                           bus.o_pop_ready, bus.o_push_ready, xp, !xp);
      end
      step();
    end
    drive(0, 0, '0, 0, 0);
  endtask

  task automatic test_full_other();
    do_reset();
    for (int i = 0; i < CAP; i++) begin
      drive(1, 2, 16'($urandom), 0, 0);
      @(negedge clk);
      n_checks++;
      if (bus.o_push_ready !== 1'b1) begin
        n_fail++; $display("FAIL fill2_ready i=%0d got=%b exp 1", i, bus.o_push_ready);
      end
      step();
    end
    drive(1, 3, 16'h00AA, 0, 0);
    @(negedge clk);
    n_checks++;
    if (bus.o_push_ready !== 1'b1 || full !== 4'b0100) begin
      n_fail++; $display("FAIL other_tree ready=%b full=%b exp 1 0100", bus.o_push_ready, full);
    end
    step();
    drive(0, 0, '0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (full !== 4'b0100 || empty !== 4'b0011) begin
      n_fail++; $display("FAIL other_status full=%b empty=%b exp 0100 0011", full, empty);
    end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 3), 16'($urandom),
            $urandom_range(0, 9) < 5, $urandom_range(0, 3));
      @(negedge clk);
      n_checks++;
      if (bus.o_push_ready === 1'b1 && bus.o_pop_ready === 1'b1) begin
        n_fail++; $display("FAIL random_both_ready k=%0d got 1 1 exp at most one", k);
      end
      step();
    end
    drive(0, 0, '0, 0, 0);
    repeat (6) step();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 16'(100 + i), 0, 0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, '0, 1, 1);
      @(negedge clk);
      n_checks++;
      if (bus.o_pop_ready !== 1'b1) begin
        n_fail++; $display("FAIL inflight_pop i=%0d got=%b exp 1", i, bus.o_pop_ready);
      end
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.o_pop_ready !== 1'b0 || bus.o_push_ready !== 1'b0) begin
      n_fail++; $display("FAIL inflight_rst_ready pop=%b push=%b exp 0 0", bus.o_pop_ready, bus.o_push_ready);
    end
    step();
    rst = 1'b0;
    drive(0, 0, '0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_pop_data_valid !== 1'b0 || empty !== 4'hF) begin
        n_fail++; $display("FAIL inflight_flush k=%0d valid=%b empty=%h exp 0 F", k,
                           bus.o_pop_data_valid, empty);
      end
      step();
    end
  endtask

  initial begin
    drive(0, 0, '0, 0, 0);
    rst = 1'b1;
    step();
    mon_en = 1'b1;
    test_reset();
    test_fill_drain();
    test_contested();
    test_full_other();
    test_random();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vpifo_port_arbiter.md
# vpifo_port_arbiter

Multi-tree ingress/egress port controller sitting between external push/pop sources and the vPIFO core (BMW SRAM PIFO with `TREE_NUM` logical trees). Accepts independent push and pop requests over valid/ready handshakes, tracks per-tree occupancy against the per-tree capacity, issues at most one legal operation per cycle to the core, and returns tagged pop results after the core's fixed pop latency. Replaces direct stimulus of the core's `i_push`/`i_pop`/`i_tree_id` pins with flow-controlled, overflow/underflow-safe access.

## Interface
- `PTW`, 16, priority/data width
- `TREE_NUM`, 4, number of logical trees
- `LEVEL`, 4, core tree depth; per-tree capacity `CAP = 2**(LEVEL+1)-2` (30)
- `POP_LAT`, 2, core cycles from `o_core_pop` to valid `i_core_pop_data`
- `TNB` (derived), `$clog2(TREE_NUM)`, tree id width (min 1)
- `i_clk  in  1  sole clock; one clock, reset synchronous active-high`
- `i_rst  in  1  synchronous reset, active-high`
- `i_push_valid  in  1` / `o_push_ready  out  1` / `i_push_tree_id  in  TNB` / `i_push_data  in  PTW`
- `i_pop_valid  in  1` / `o_pop_ready  out  1` / `i_pop_tree_id  in  TNB`
- `o_pop_data_valid  out  1` / `o_pop_data  out  PTW` / `o_pop_tree_id  out  TNB`, pop result
- `o_core_push  out  1` / `o_core_pop  out  1` / `o_core_tree_id  out  TNB` / `o_core_push_data  out  PTW`, to core
- `i_core_pop_data  in  PTW`, from core
- `o_full  out  TREE_NUM`, `o_empty  out  TREE_NUM`, per-tree status
- `o_stall_cnt  out  TREE_NUM*16`, per-tree stall counters (see Configuration)

## Operation
- Per-tree occupancy counter `occ[t]`, width `$clog2(CAP+1)`.
- Push legal: `i_push_tree_id < TREE_NUM` and `occ[id] < CAP`. Pop legal: id in range and `occ[id] > 0`.
- Arbiter: if only one side is valid and legal, it is granted. If both are, grant alternates using a priority bit; pop wins first after reset; the bit flips only on a contested grant.
- `o_push_ready`/`o_pop_ready` = legal and granted. These are combinational from the inputs and state. Illegal requests are never dropped; they are held by the source.
- Handshake updates `occ` at the same edge: +1 on push, −1 on pop. Push and pop are never both granted, so there is no same-cycle conflict.
- `o_full[t] = (occ[t]==CAP)`, `o_empty[t] = (occ[t]==0)`, both registered-state derived.
- Pop tag pipeline: a shift register of depth `POP_LAT+1` carrying (valid, tree_id). It captures `i_core_pop_data` into `o_pop_data` when the tag reaches the core-return stage.
- Out-of-range tree id: never ready, no state change.

## Timing
- Reset values: `occ`=0, priority=pop, `o_core_*`=0, `o_pop_data_valid`=0, `o_pop_data`=0, `o_pop_tree_id`=0, `o_full`=0, `o_empty`=all 1, tag pipeline cleared, stall counters 0. Both readies are 0 while `i_rst`=1.
- Handshake in cycle N drives registered `o_core_*` in N+1 (`o_core_push_data` is 0 for pops).
- Pop result: `o_pop_data_valid` is high in cycle N+2+POP_LAT for exactly one cycle (4 at default).
- Sustained throughput: one operation per cycle total.
- Reset mid-operation: in-flight pop tags are discarded and no `o_pop_data_valid` is produced afterwards. The core is reset by the same `i_rst`.
- A pop to a tree whose last element was pushed in cycle N is legal in N+1.

## Configuration
- `VPIFO_PORT_STATS_EN` defined:
  - `o_stall_cnt[t*16 +: 16]` counts cycles in which a valid request targeting tree t is not ready due to full or empty.
  - Counting is per side, so a push stall and a pop stall in the same cycle add 2.
  - Counters saturate at 0xFFFF; arbitration losses are not counted.
- Undefined: port still present, driven constant 0, no counter logic.

## Structure
- Shared package `vpifo_pkg`:
  - `vpifo_cap(level)` function
  - `STALL_CNT_W = 16`
  - `op_e {OP_IDLE, OP_PUSH, OP_POP}` used for the registered core command
- One sub-module, `vpifo_pop_tag_pipe` (params `TNB`, `DEPTH`): tag shift register with synchronous clear.

## Test plan
Default parameters; behavioural core model with `POP_LAT`=2.
- Push 30 items 4096..4125 to tree 0 → all accepted back-to-back; `o_full[0]`=1 after the 30th. A 31st push holds `o_push_ready`=0.
- Pop tree 0 ×30 → each `o_pop_data_valid` arrives 4 cycles after its handshake with `o_pop_tree_id`=0; `o_empty[0]`=1 at the end. A further pop gets `o_pop_ready`=0.
- After reset, push to tree 1 and pop from tree 0 (occ 5) held valid continuously → grants pop, push, pop, push…; occ[0] reaches 0, then push is granted every cycle.
- Fill tree 2 to 30 → push to tree 3 still accepted same cycle; `o_full`=4'b0100.
- Assert `i_rst` for one cycle with two pops in flight → no `o_pop_data_valid` afterwards; `o_empty`=4'hF, readies 0 during reset.
- With `VPIFO_PORT_STATS_EN`: push to full tree 0 held 5 cycles → stall count for tree 0 = 5. Without the macro → `o_stall_cnt`=0.
